// File: rtl/demux.sv
// Registered 1-to-8 demultiplexer with idle-high outputs.
// The selected output carries the input data while enabled. Every other output,
// and every output while disabled or in reset, idles at all-ones. With a data
// width of 1 this acts as a gated 3-to-8 active-low decoder.
module demux #(
    parameter int unsigned DataWidth = 1
) (
    input  logic                 Clock,
    input  logic                 Reset_N,
    input  logic [2:0]           Select,
    input  logic                 Enable,
    input  logic [DataWidth-1:0] DIn,
    output logic [DataWidth-1:0] O0,
    output logic [DataWidth-1:0] O1,
    output logic [DataWidth-1:0] O2,
    output logic [DataWidth-1:0] O3,
    output logic [DataWidth-1:0] O4,
    output logic [DataWidth-1:0] O5,
    output logic [DataWidth-1:0] O6,
    output logic [DataWidth-1:0] O7
);

    localparam int unsigned NumOut = 8;

    logic [DataWidth-1:0] out_d [NumOut];
    logic [DataWidth-1:0] out_q [NumOut];

    // Next state: only the selected output takes the data; the rest go idle.
    // Each output is derived from the current inputs alone, so a select change
    // moves the data from the old output to the new one on the same edge.
    always_comb begin
        for (int k = 0; k < NumOut; k++) begin
            out_d[k] = {DataWidth{1'b1}};
            if (Enable && (Select == 3'(k))) begin
                out_d[k] = DIn;
            end
        end
    end

    // Output registers. Reset forces the idle value at once, and no state survives it.
    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            for (int k = 0; k < NumOut; k++) begin
                out_q[k] <= {DataWidth{1'b1}};
            end
        end else begin
            for (int k = 0; k < NumOut; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    // The outputs come straight from the flops, so no input reaches them combinationally.
    assign O0 = out_q[0];
    assign O1 = out_q[1];
    assign O2 = out_q[2];
    assign O3 = out_q[3];
    assign O4 = out_q[4];
    assign O5 = out_q[5];
    assign O6 = out_q[6];
    assign O7 = out_q[7];

endmodule

// File: tb/tb_demux.sv
// Directed testbench for demux. It drives a 1-bit instance and an 8-bit instance
// from the same clock, reset, select and enable signals.
module tb_demux;

    logic       Clock;
    logic       Reset_N;
    logic [2:0] Select;
    logic       Enable;
    logic       din1;
    logic [7:0] din8;

    logic       a0, a1, a2, a3, a4, a5, a6, a7;
    logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7;

    int checks = 0;
    int errors = 0;

    demux #(.DataWidth(1)) u_dut1 (
        .Clock   (Clock),
        .Reset_N (Reset_N),
        .Select  (Select),
        .Enable  (Enable),
        .DIn     (din1),
        .O0      (a0),
        .O1      (a1),
        .O2      (a2),
        .O3      (a3),
        .O4      (a4),
        .O5      (a5),
        .O6      (a6),
        .O7      (a7)
    );

    demux #(.DataWidth(8)) u_dut8 (
        .Clock   (Clock),
        .Reset_N (Reset_N),
        .Select  (Select),
        .Enable  (Enable),
        .DIn     (din8),
        .O0      (b0),
        .O1      (b1),
        .O2      (b2),
        .O3      (b3),
        .O4      (b4),
        .O5      (b5),
        .O6      (b6),
        .O7      (b7)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = {a7, a6, a5, a4, a3, a2, a1, a0};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed {O7..O0}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [63:0] exp);
        logic [63:0] got;
        got = {b7, b6, b5, b4, b3, b2, b1, b0};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed {O7..O0}=%h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        logic [7:0] exp1;
        Reset_N = 1'b1;
        Enable  = 1'b1;
        Select  = 3'd0;
        din1    = 1'b0;
        din8    = 8'h00;

        // The reset takes effect before any clock edge has occurred.
        #2 Reset_N = 1'b0;
        #1;
        chk1("reset_async_w1", 8'hFF);
        chk8("reset_async_w8", {8{8'hFF}});
        tick();
        chk1("reset_hold", 8'hFF);
        @(negedge Clock);
        Reset_N = 1'b1;
        tick();
        chk1("release_sel0", 8'hFE);

        // Walk the select through all eight outputs.
        for (int s = 0; s < 8; s++) begin
            @(negedge Clock);
            Select = 3'(s);
            tick();
            exp1 = ~(8'h01 << s);
            chk1($sformatf("walk_sel%0d", s), exp1);
        end

        // Disable the outputs, then change the select while they are disabled.
        @(negedge Clock);
        Enable = 1'b0;
        Select = 3'd1;
        tick();
        chk1("disabled_sel1", 8'hFF);
        @(negedge Clock);
        Select = 3'd2;
        tick();
        chk1("disabled_sel2", 8'hFF);
        @(negedge Clock);
        Enable = 1'b1;
        tick();
        chk1("reenable_sel2", 8'hFB);

        // Enable falls and the select changes on the same edge.
        @(negedge Clock);
        Enable = 1'b0;
        Select = 3'd5;
        tick();
        chk1("en_fall_sel_change", 8'hFF);

        // Latency: a select change in mid-cycle is not visible until the next edge.
        @(negedge Clock);
        Enable = 1'b1;
        Select = 3'd3;
        tick();
        chk1("lat_sel3", 8'hF7);
        #3 Select = 3'd6;
        #1;
        chk1("lat_midcycle_hold", 8'hF7);
        tick();
        chk1("lat_sel6", 8'hBF);

        // Assert reset between edges while the outputs are active.
        @(negedge Clock);
        Select = 3'd3;
        tick();
        chk1("mid_run_sel3", 8'hF7);
        #2 Reset_N = 1'b0;
        #1;
        chk1("mid_reset_async", 8'hFF);
        #1 Reset_N = 1'b1;
        #1;
        chk1("mid_reset_released_no_edge", 8'hFF);
        tick();
        chk1("mid_reset_rebuilt", 8'hF7);

        // An all-ones data input leaves every output idle.
        @(negedge Clock);
        din1 = 1'b1;
        tick();
        chk1("din_ones_w1", 8'hFF);

        // 8-bit data is passed through unchanged.
        @(negedge Clock);
        Select = 3'd5;
        din8   = 8'hA5;
        tick();
        chk8("w8_sel5_a5", 64'hFFFF_A5FF_FFFF_FFFF);
        @(negedge Clock);
        Select = 3'd0;
        din8   = 8'h3C;
        tick();
        chk8("w8_sel0_3c", 64'hFFFF_FFFF_FFFF_FF3C);
        @(negedge Clock);
        Select = 3'd5;
        din8   = 8'hFF;
        tick();
        chk8("w8_din_ff", {8{8'hFF}});
        @(negedge Clock);
        Select = 3'd7;
        din8   = 8'h00;
        tick();
        chk8("w8_sel7_00", 64'h00FF_FFFF_FFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
